// File: rtl/h2o_serial_accum.sv
// Serial hidden-to-output layer engine.
// Takes one Q15 hidden element per handshake, scales it by the matching
// constant weight row, accumulates the frame and emits one saturated
// biased result per frame on a valid/ready output.
module h2o_serial_accum #(
  parameter int                 N_HIDDEN = 20,
  parameter int                 DATA_W   = 32,
  parameter int                 FRAC     = 15,
  parameter int                 ACC_W    = 40,
  parameter logic signed [31:0] BIAS     = 32'sd0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic signed [DATA_W-1:0] h_data,
  input  logic                     h_valid,
  input  logic                     h_last,
  output logic                     h_ready,
  output logic signed [DATA_W-1:0] y_data,
  output logic                     y_valid,
  input  logic                     y_ready,
  output logic                     frame_err
);

  localparam int COEF_W = 16;
  localparam int IDX_W  = $clog2(N_HIDDEN);
  localparam int MUL_W  = DATA_W + COEF_W;
  localparam int PROD_W = MUL_W - FRAC;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_HIDDEN - 1);

  localparam logic signed [ACC_W:0] SAT_MAX =
    {{(ACC_W - DATA_W + 2){1'b0}}, {(DATA_W - 1){1'b1}}};
  localparam logic signed [ACC_W:0] SAT_MIN =
    {{(ACC_W - DATA_W + 2){1'b1}}, {(DATA_W - 1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_DRAIN,
    S_OUT
  } state_t;

  // Weight row i in Q15; all magnitudes stay below 2^14.
  function automatic logic signed [COEF_W-1:0] coef(input logic [IDX_W-1:0] i);
    logic signed [COEF_W-1:0] c;
    c = '0;
    case (int'(i))
      0:  c =  16'sd800;
      1:  c = -16'sd2047;
      2:  c =  16'sd1374;
      3:  c =  16'sd2448;
      4:  c = -16'sd2532;
      5:  c = -16'sd3970;
      6:  c = -16'sd2782;
      7:  c =  16'sd5063;
      8:  c = -16'sd7033;
      9:  c =  16'sd6124;
      10: c = -16'sd1435;
      11: c =  16'sd3729;
      12: c = -16'sd4799;
      13: c =  16'sd7123;
      14: c =  16'sd1851;
      15: c = -16'sd5187;
      16: c =  16'sd8427;
      17: c = -16'sd6695;
      18: c = -16'sd4377;
      19: c = -16'sd1838;
      default: c = '0;
    endcase
    return c;
  endfunction

  // Full-precision product, arithmetic shift by FRAC: floor, no rounding,
  // so the result matches the row multipliers bit for bit.
  function automatic logic signed [PROD_W-1:0] scale(
    input logic signed [DATA_W-1:0] x,
    input logic signed [COEF_W-1:0] c
  );
    logic signed [MUL_W-1:0] xe;
    logic signed [MUL_W-1:0] ce;
    logic signed [MUL_W-1:0] m;
    xe = {{COEF_W{x[DATA_W-1]}}, x};
    ce = {{DATA_W{c[COEF_W-1]}}, c};
    m  = xe * ce;
    return PROD_W'(m >>> FRAC);
  endfunction

  // Clamp the biased sum into the signed output range.
  function automatic logic signed [DATA_W-1:0] sat(input logic signed [ACC_W:0] s);
    logic signed [DATA_W-1:0] r;
    if (s > SAT_MAX)      r = {1'b0, {(DATA_W - 1){1'b1}}};
    else if (s < SAT_MIN) r = {1'b1, {(DATA_W - 1){1'b0}}};
    else                  r = DATA_W'(s);
    return r;
  endfunction

  state_t                    r_state;
  logic [IDX_W-1:0]          r_idx;
  logic signed [ACC_W-1:0]   r_acc;
  logic signed [PROD_W-1:0]  r_prod_p1;
  logic                      r_prod_vld_p1;
  logic signed [DATA_W-1:0]  r_y_data;
  logic                      r_y_valid;
  logic                      r_frame_err;

  logic                      w_accept;
  logic                      w_at_last;
  logic                      w_frame_bad;
  logic signed [ACC_W-1:0]   w_prod_ext;
  logic signed [ACC_W:0]     w_bias_ext;
  logic signed [ACC_W:0]     w_biased;

  assign h_ready     = (r_state == S_ACCUM);
  assign w_accept    = h_valid && h_ready;
  assign w_at_last   = (r_idx == LAST_IDX);
  // Misframed when the last flag and the element position disagree.
  assign w_frame_bad = w_accept && (h_last != w_at_last);

  assign w_prod_ext  = {{(ACC_W - PROD_W){r_prod_p1[PROD_W-1]}}, r_prod_p1};
  assign w_bias_ext  = {{(ACC_W + 1 - 32){BIAS[31]}}, BIAS};
  assign w_biased    = $signed({r_acc[ACC_W-1], r_acc}) + w_bias_ext;

  assign y_data      = r_y_data;
  assign y_valid     = r_y_valid;
  assign frame_err   = r_frame_err;

  // Stage p0 -> p1: scale the accepted element by its weight row.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_prod_p1 <= scale(h_data, coef(r_idx));
    end
  end

  // Stage p1 -> acc: frame control, accumulation, framing check and output hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_idx         <= '0;
      r_acc         <= '0;
      r_prod_vld_p1 <= 1'b0;
      r_y_data      <= '0;
      r_y_valid     <= 1'b0;
      r_frame_err   <= 1'b0;
    end else begin
      r_frame_err   <= 1'b0;
      r_prod_vld_p1 <= 1'b0;
      if (r_prod_vld_p1) begin
        r_acc <= r_acc + w_prod_ext;
      end
      case (r_state)
        S_IDLE: begin
          r_state <= S_ACCUM;
        end
        S_ACCUM: begin
          if (w_accept) begin
            if (w_frame_bad) begin
              // Drop the whole frame, including any product still in flight.
              r_acc       <= '0;
              r_idx       <= '0;
              r_frame_err <= 1'b1;
            end else begin
              r_prod_vld_p1 <= 1'b1;
              r_idx         <= r_idx + IDX_W'(1);
              if (w_at_last) begin
                r_state <= S_DRAIN;
              end
            end
          end
        end
        S_DRAIN: begin
          // Wait for the final product to land in the accumulator.
          if (!r_prod_vld_p1) begin
            r_y_data  <= sat(w_biased);
            r_y_valid <= 1'b1;
            r_state   <= S_OUT;
          end
        end
        S_OUT: begin
          if (y_ready) begin
            r_y_valid <= 1'b0;
            r_acc     <= '0;
            r_idx     <= '0;
            r_state   <= S_ACCUM;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_h2o_serial_accum.sv
// Self-checking bench for h2o_serial_accum: directed vector table, a
// scoreboard queue of expected frame results, and hand-written sequences
// for latency, backpressure, framing errors and mid-frame reset.
module tb_h2o_serial_accum;

  localparam int     N      = 20;
  localparam longint BIAS_B = 64'sd2147479552;

  logic               clk = 1'b0;
  logic               rst_n;
  logic signed [31:0] h_data;
  logic               h_valid;
  logic               h_last;
  logic               h_ready;
  logic               h_ready_b;
  logic signed [31:0] y_data;
  logic signed [31:0] y_data_b;
  logic               y_valid;
  logic               y_valid_b;
  logic               y_ready;
  logic               frame_err;
  logic               frame_err_b;

  int n_checks = 0;
  int n_pass   = 0;

  int C[N] = '{800, -2047, 1374, 2448, -2532, -3970, -2782, 5063, -7033, 6124,
               -1435, 3729, -4799, 7123, 1851, -5187, 8427, -6695, -4377, -1838};
  int cur[N];

  typedef struct {
    longint y;
    longint yb;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    int     mode;
    int     fill;
    int     hot_i;
    int     hot_v;
    int     bub;
    longint ey;
    longint eyb;
  } vec_t;
  vec_t vt[8];

  bit seen;

  h2o_serial_accum dut (
    .clk(clk), .rst_n(rst_n), .h_data(h_data), .h_valid(h_valid), .h_last(h_last),
    .h_ready(h_ready), .y_data(y_data), .y_valid(y_valid), .y_ready(y_ready),
    .frame_err(frame_err)
  );

  h2o_serial_accum #(.BIAS(32'sh7FFFF000)) dut_b (
    .clk(clk), .rst_n(rst_n), .h_data(h_data), .h_valid(h_valid), .h_last(h_last),
    .h_ready(h_ready_b), .y_data(y_data_b), .y_valid(y_valid_b), .y_ready(y_ready),
    .frame_err(frame_err_b)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, required finish before 400000");
    $fatal(1);
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d required %0d", name, act, exp);
  endtask

  task automatic fail(input string name, input string what);
    n_checks++;
    $display("FAIL %s: %s", name, what);
  endtask

  function automatic longint sat32(input longint s);
    if (s > 64'sd2147483647) return 64'sd2147483647;
    if (s < -64'sd2147483648) return -64'sd2147483648;
    return s;
  endfunction

  function automatic longint model_sum();
    longint s = 0;
    for (int j = 0; j < N; j++) s += (longint'(cur[j]) * longint'(C[j])) >>> 15;
    return s;
  endfunction

  // Scoreboard: pop one expectation per new output word.
  always @(negedge clk) begin
    if (!rst_n) begin
      seen = 1'b0;
    end else if (y_valid && !seen) begin
      seen = 1'b1;
      chk("y_valid_b", longint'(y_valid_b), 1);
      if (sbq.size() == 0) begin
        fail("unexpected_y", $sformatf("got y_valid=1 y_data=%0d required no output", y_data));
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("y_data", longint'(y_data), e.y);
        chk("y_data_bias", longint'(y_data_b), e.yb);
      end
    end else if (!y_valid) begin
      seen = 1'b0;
    end
  end

  task automatic bubble(input int n);
    repeat (n) begin
      @(negedge clk);
      h_valid = 1'b0;
    end
  endtask

  task automatic send(input int d, input bit l);
    int g = 0;
    @(negedge clk);
    h_data  = d;
    h_last  = l;
    h_valid = 1'b1;
    while (!h_ready && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (g >= 200) fail("send_timeout", "got h_ready=0 for 200 cycles required 1");
    @(posedge clk);
  endtask

  task automatic wait_drain();
    int g = 0;
    while ((sbq.size() != 0 || y_valid) && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (g >= 100) fail("drain_timeout", $sformatf("got %0d pending results required 0", sbq.size()));
  endtask

  task automatic push_exp(input longint y, input longint yb);
    exp_t e;
    e.y  = y;
    e.yb = yb;
    sbq.push_back(e);
  endtask

  // mode 0: fill with one hot element; mode 1: +/-fill signed like C; mode 2: cur preset.
  task automatic run_frame(input int mode, input int fill, input int hot_i, input int hot_v,
                           input int bub, input int err_at, input bit use_model,
                           input longint ey, input longint eyb);
    int  nel;
    bit  lf;
    longint s;
    for (int j = 0; j < N; j++) begin
      if (mode == 0)      cur[j] = (j == hot_i) ? hot_v : fill;
      else if (mode == 1) cur[j] = (C[j] > 0) ? fill : -fill;
    end
    s = model_sum();
    if (use_model) begin
      ey  = sat32(s);
      eyb = sat32(s + BIAS_B);
    end
    nel = (err_at >= 0 && err_at < N - 1) ? err_at + 1 : N;
    for (int j = 0; j < nel; j++) begin
      if (bub != 0) bubble(int'($urandom_range(0, 2)));
      if (err_at >= 0) lf = (j == err_at) && (err_at != N - 1);
      else             lf = (j == N - 1);
      if (err_at < 0 && j == N - 1) push_exp(ey, eyb);
      send(cur[j], lf);
    end
    if (err_at >= 0) begin
      @(negedge clk);
      h_valid = 1'b0;
      chk("frame_err_pulse", longint'(frame_err), 1);
      chk("frame_err_b_pulse", longint'(frame_err_b), 1);
      chk("h_ready_after_err", longint'(h_ready), 1);
      @(negedge clk);
      chk("frame_err_clear", longint'(frame_err), 0);
    end else begin
      bubble(1);
    end
    wait_drain();
  endtask

  initial begin
    rst_n   = 1'b0;
    h_data  = '0;
    h_valid = 1'b0;
    h_last  = 1'b0;
    y_ready = 1'b1;

    vt[0] = '{0,  32768, -1, 0,     0, -64'sd5756,       64'sd2147473796};
    vt[1] = '{0,  0,      1, 1,     0, -64'sd1,          64'sd2147479551};
    vt[2] = '{0,  0,      0, 1,     0,  64'sd0,          64'sd2147479552};
    vt[3] = '{0,  0,     16, 32768, 0,  64'sd8427,       64'sd2147483647};
    vt[4] = '{0, -32768, -1, 0,     1,  64'sd5756,       64'sd2147483647};
    vt[5] = '{1,  2147483647, -1, 0, 0, 64'sd2147483647, 64'sd2147483647};
    vt[6] = '{1, -2147483647, -1, 0, 1, -64'sd2147483648, -64'sd2147483648};
    vt[7] = '{0,  32768, -1, 0,     1, -64'sd5756,       64'sd2147473796};

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_h_ready", longint'(h_ready), 0);
    chk("rst_h_ready_b", longint'(h_ready_b), 0);
    chk("rst_y_valid", longint'(y_valid), 0);
    chk("rst_y_data", longint'(y_data), 0);
    chk("rst_frame_err", longint'(frame_err), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("h_ready_after_release", longint'(h_ready), 1);

    // Latency and single-cycle y_valid with the all-ones frame
    for (int j = 0; j < N; j++) begin
      if (j == N - 1) push_exp(-64'sd5756, 64'sd2147473796);
      send(32768, j == N - 1);
    end
    @(negedge clk);
    h_valid = 1'b0;
    chk("lat_e0_y_valid", longint'(y_valid), 0);
    chk("lat_e0_h_ready", longint'(h_ready), 0);
    @(negedge clk);
    chk("lat_e1_y_valid", longint'(y_valid), 0);
    @(negedge clk);
    chk("lat_e2_y_valid", longint'(y_valid), 1);
    chk("lat_e2_y_data", longint'(y_data), -64'sd5756);
    @(negedge clk);
    chk("lat_e3_y_valid", longint'(y_valid), 0);
    chk("lat_e3_h_ready", longint'(h_ready), 1);
    wait_drain();

    // Directed vector table
    for (int v = 0; v < 8; v++) begin
      run_frame(vt[v].mode, vt[v].fill, vt[v].hot_i, vt[v].hot_v, vt[v].bub, -1, 1'b0,
                vt[v].ey, vt[v].eyb);
    end

    // Random frame, bubble-free then with bubbles: same expected result
    for (int j = 0; j < N; j++) cur[j] = int'($urandom);
    run_frame(2, 0, -1, 0, 0, -1, 1'b1, 0, 0);
    run_frame(2, 0, -1, 0, 1, -1, 1'b1, 0, 0);

    // Backpressure: hold y_ready low, present next element 0 early
    @(negedge clk);
    y_ready = 1'b0;
    for (int j = 0; j < N; j++) cur[j] = 32768;
    for (int j = 0; j < N; j++) begin
      if (j == N - 1) push_exp(-64'sd5756, 64'sd2147473796);
      send(32768, j == N - 1);
    end
    begin
      int g = 0;
      @(negedge clk);
      h_valid = 1'b0;
      while (!y_valid && g < 20) begin
        @(negedge clk);
        g++;
      end
      if (g >= 20) fail("bp_timeout", "got y_valid=0 for 20 cycles required 1");
    end
    h_data  = 32768;
    h_last  = 1'b0;
    h_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk("bp_y_valid", longint'(y_valid), 1);
      chk("bp_y_data", longint'(y_data), -64'sd5756);
      chk("bp_h_ready", longint'(h_ready), 0);
      @(negedge clk);
    end
    y_ready = 1'b1;
    chk("bp_h_ready_pre_hs", longint'(h_ready), 0);
    @(negedge clk);
    chk("bp_y_valid_post_hs", longint'(y_valid), 0);
    chk("bp_h_ready_post_hs", longint'(h_ready), 1);
    for (int j = 1; j < N; j++) begin
      if (j == N - 1) push_exp(-64'sd5756, 64'sd2147473796);
      send(32768, j == N - 1);
    end
    bubble(1);
    wait_drain();

    // Framing errors: early last, then missing last, then a clean frame
    run_frame(0, 32768, -1, 0, 0, 5, 1'b0, 0, 0);
    run_frame(0, 32768, -1, 0, 0, N - 1, 1'b0, 0, 0);
    run_frame(0, 32768, -1, 0, 0, -1, 1'b0, -64'sd5756, 64'sd2147473796);

    // Reset after 10 accepted elements; previous y_data is nonzero
    for (int j = 0; j < 10; j++) send(32768, 1'b0);
    @(negedge clk);
    rst_n   = 1'b0;
    h_valid = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("mid_rst_h_ready", longint'(h_ready), 0);
      chk("mid_rst_y_valid", longint'(y_valid), 0);
      chk("mid_rst_y_data", longint'(y_data), 0);
      chk("mid_rst_frame_err", longint'(frame_err), 0);
      @(negedge clk);
    end
    rst_n = 1'b1;
    run_frame(0, 32768, -1, 0, 0, -1, 1'b0, -64'sd5756, 64'sd2147473796);

    repeat (3) @(negedge clk);
    chk("final_queue_empty", longint'(sbq.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
